// File: rtl/dac_wb_wrapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_wb_wrapper_pkg
// Description : Register map, IRQ bit indices and shared types for the
//               Wishbone DAC playback peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package dac_wb_wrapper_pkg;

    // Word addresses (byte offset >> 2), decoded from adr[8:2]
    localparam logic [6:0] c_ADR_DATA   = 7'h00;
    localparam logic [6:0] c_ADR_CTRL   = 7'h01;
    localparam logic [6:0] c_ADR_STATUS = 7'h02;
    localparam logic [6:0] c_ADR_PRESC  = 7'h03;
    localparam logic [6:0] c_ADR_THRESH = 7'h04;
    localparam logic [6:0] c_ADR_IM     = 7'h3F;
    localparam logic [6:0] c_ADR_RIS    = 7'h40;
    localparam logic [6:0] c_ADR_MIS    = 7'h41;
    localparam logic [6:0] c_ADR_IC     = 7'h42;

    localparam int c_CTRL_EN    = 0;
    localparam int c_CTRL_FLUSH = 1;
    localparam int c_CTRL_ZOU   = 2;

    localparam int c_IRQ_LOW   = 0;
    localparam int c_IRQ_UNDER = 1;
    localparam int c_IRQ_OVF   = 2;
    localparam int c_NUM_IRQ   = 3;

    localparam logic [31:0] c_RD_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic zou;
        logic en;
    } ctrl_t;

endpackage : dac_wb_wrapper_pkg
`default_nettype wire

// File: rtl/dac_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_fifo
// Description : Synchronous sample FIFO with flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [DATA_W-1:0]          i_din,
    output logic [DATA_W-1:0]          o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              w_full;
    logic              w_empty;
    logic              w_wr;
    logic              w_rd;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_rd    = i_pop & ~w_empty;
    // A push into a full FIFO is accepted only when a pop frees a slot the same cycle
    assign w_wr    = i_push & (~w_full | w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule : dac_sample_fifo
`default_nettype wire

// File: rtl/dac_wb_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : dac_wb_wrapper
// Description : Wishbone DAC playback peripheral: sample FIFO, rate timer, IRQs.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_wb_wrapper
    import dac_wb_wrapper_pkg::*;
#(
    parameter int DAC_WIDTH  = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int PRESC_W    = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [31:0]           wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [DAC_WIDTH-1:0]  dac_val,
    output logic                  dac_update,
    output logic                  dac_ena,
    output logic                  irq
);

    localparam int c_LW = $clog2(FIFO_DEPTH) + 1;

    ctrl_t                  r_ctrl;
    logic [PRESC_W-1:0]     r_presc;
    logic [PRESC_W-1:0]     r_cnt;
    logic [c_LW-1:0]        r_thresh;
    logic [c_NUM_IRQ-1:0]   r_im;
    logic [c_NUM_IRQ-1:0]   r_ris;
    logic                   r_ack;
    logic [DAC_WIDTH-1:0]   r_dac_val;
    logic                   r_dac_update;

    logic                   w_acc;
    logic                   w_wr;
    logic [6:0]             w_adr;
    logic                   w_push;
    logic                   w_flush;
    logic                   w_tick;
    logic                   w_pop;
    logic [DAC_WIDTH-1:0]   w_dout;
    logic                   w_full;
    logic                   w_empty;
    logic [c_LW-1:0]        w_level;
    logic [c_NUM_IRQ-1:0]   w_evt;
    logic [c_NUM_IRQ-1:0]   w_ic;
    logic [31:0]            w_status;
    logic                   w_unused;

    assign w_unused = &{1'b0, wbs_sel_i, wbs_adr_i[31:9], wbs_adr_i[1:0], wbs_dat_i};

    assign w_acc   = wbs_cyc_i & wbs_stb_i;
    // Writes act only in the first cycle of an access, before ack is raised
    assign w_wr    = w_acc & wbs_we_i & ~r_ack;
    assign w_adr   = wbs_adr_i[8:2];
    assign w_push  = w_wr & (w_adr == c_ADR_DATA);
    assign w_flush = w_wr & (w_adr == c_ADR_CTRL) & wbs_dat_i[c_CTRL_FLUSH];
    assign w_ic    = (w_wr && (w_adr == c_ADR_IC)) ? wbs_dat_i[c_NUM_IRQ-1:0] : '0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_ctrl   <= '0;
            r_presc  <= '0;
            r_thresh <= c_LW'(FIFO_DEPTH / 4);
            r_im     <= '0;
        end else begin
            r_ack <= w_acc & ~r_ack;
            if (w_wr) begin
                case (w_adr)
                    c_ADR_CTRL: begin
                        r_ctrl.en  <= wbs_dat_i[c_CTRL_EN];
                        r_ctrl.zou <= wbs_dat_i[c_CTRL_ZOU];
                    end
                    c_ADR_PRESC:  r_presc  <= wbs_dat_i[PRESC_W-1:0];
                    c_ADR_THRESH: r_thresh <= wbs_dat_i[c_LW-1:0];
                    c_ADR_IM:     r_im     <= wbs_dat_i[c_NUM_IRQ-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Sample-rate timer; the >= guards against PRESC being lowered mid-count
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt <= '0;
        end else if (!r_ctrl.en || (r_cnt >= r_presc)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PRESC_W'(1);
        end
    end

    assign w_tick = r_ctrl.en & (r_cnt == r_presc);
    assign w_pop  = w_tick & ~w_empty;

    dac_sample_fifo #(
        .DATA_W (DAC_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (wbs_dat_i[DAC_WIDTH-1:0]),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_dac_val    <= '0;
            r_dac_update <= 1'b0;
        end else begin
            r_dac_update <= w_pop;
            if (w_pop) begin
                r_dac_val <= w_dout;
            end else if (w_evt[c_IRQ_UNDER] && r_ctrl.zou) begin
                r_dac_val <= '0;
            end
        end
    end

    assign w_evt[c_IRQ_LOW]   = r_ctrl.en & (w_level <= r_thresh);
    assign w_evt[c_IRQ_UNDER] = w_tick & w_empty;
    assign w_evt[c_IRQ_OVF]   = w_push & w_full & ~w_pop & ~w_flush;

    // New events take priority over a same-cycle clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ris <= '0;
        end else begin
            r_ris <= (r_ris & ~w_ic) | w_evt;
        end
    end

    assign w_status = 32'({w_level, 5'b0, (r_ctrl.en & ~w_empty), w_full, w_empty});

    always_comb begin
        wbs_dat_o = c_RD_DEFAULT;
        case (w_adr)
            c_ADR_DATA:   wbs_dat_o = '0;
            c_ADR_CTRL:   wbs_dat_o = 32'({r_ctrl.zou, 1'b0, r_ctrl.en});
            c_ADR_STATUS: wbs_dat_o = w_status;
            c_ADR_PRESC:  wbs_dat_o = 32'(r_presc);
            c_ADR_THRESH: wbs_dat_o = 32'(r_thresh);
            c_ADR_IM:     wbs_dat_o = 32'(r_im);
            c_ADR_RIS:    wbs_dat_o = 32'(r_ris);
            c_ADR_MIS:    wbs_dat_o = 32'(r_ris & r_im);
            c_ADR_IC:     wbs_dat_o = '0;
            default:      wbs_dat_o = c_RD_DEFAULT;
        endcase
    end

    assign wbs_ack_o  = r_ack;
    assign dac_val    = r_dac_val;
    assign dac_update = r_dac_update;
    assign dac_ena    = r_ctrl.en;
    assign irq        = |(r_ris & r_im);

endmodule : dac_wb_wrapper
`default_nettype wire

// File: tb/tb_dac_wb_wrapper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dac_wb_wrapper
// Description : Directed scoreboard bench for the Wishbone DAC peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_wb_wrapper;

    localparam logic [31:0] A_DATA   = 32'h000;
    localparam logic [31:0] A_CTRL   = 32'h004;
    localparam logic [31:0] A_STATUS = 32'h008;
    localparam logic [31:0] A_PRESC  = 32'h00C;
    localparam logic [31:0] A_THRESH = 32'h010;
    localparam logic [31:0] A_IM     = 32'h0FC;
    localparam logic [31:0] A_RIS    = 32'h100;
    localparam logic [31:0] A_IC     = 32'h108;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat_w = '0;
    logic [31:0] adr = '0;
    logic        ack;
    logic [31:0] dat_r;
    logic [11:0] dac_val;
    logic        dac_update;
    logic        dac_ena;
    logic        irq;

    int          total = 0;
    int          bad   = 0;
    int          cycle = 0;
    int          gap_chk = 0;
    int          last_t  = -1;
    logic [11:0] sb [$];
    logic [11:0] m_exp;
    logic [31:0] rd;

    dac_wb_wrapper dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (dat_w),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .dac_val    (dac_val),
        .dac_update (dac_update),
        .dac_ena    (dac_ena),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every DAC update must match the next expected sample
    always @(negedge clk) begin
        if (!rst && dac_update) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_update: got %h expected no update", dac_val);
            end else begin
                m_exp = sb.pop_front();
                chk("dac_val_stream", 32'(dac_val), 32'(m_exp));
            end
            if (gap_chk != 0) begin
                if (last_t >= 0) chk("update_gap", 32'(cycle - last_t), 32'(gap_chk));
                last_t = cycle;
            end
        end
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 10);
        if (!ack) begin
            total++; bad++;
            $display("FAIL wb_write_timeout: got no ack expected ack at adr %h", a);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 10);
        if (!ack) begin
            total++; bad++;
            $display("FAIL wb_read_timeout: got no ack expected ack at adr %h", a);
        end
        d = dat_r;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_sb_empty(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stream_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_dac_val", 32'(dac_val), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        @(negedge clk); rst = 1'b0;
        chk("rst_ena", 32'(dac_ena), 32'd0);
        wb_read(A_STATUS, rd); chk("rst_status", rd, 32'h1);
        wb_read(A_THRESH, rd); chk("rst_thresh", rd, 32'd4);
        wb_read(A_CTRL, rd);   chk("rst_ctrl", rd, 32'd0);
        wb_read(A_RIS, rd);    chk("rst_ris", rd, 32'd0);

        // T1: three samples at one per four clocks, then underrun
        wb_write(A_PRESC, 32'd3);
        gap_chk = 4; last_t = -1;
        wb_write(A_DATA, 32'h123); sb.push_back(12'h123);
        wb_write(A_DATA, 32'h456); sb.push_back(12'h456);
        wb_write(A_DATA, 32'hABC); sb.push_back(12'hABC);
        wb_write(A_CTRL, 32'h1);
        chk("t1_ena", 32'(dac_ena), 32'd1);
        wait_sb_empty(60);
        repeat (8) @(posedge clk);
        #1;
        gap_chk = 0;
        chk("t1_hold_val", 32'(dac_val), 32'hABC);
        wb_read(A_RIS, rd); chk("t1_ris", rd, 32'h3);
        wb_write(A_CTRL, 32'h0);
        wb_write(A_IC, 32'h7);
        wb_read(A_RIS, rd); chk("t1_ris_clr", rd, 32'h0);

        // T2: zero-on-underrun and interrupt mask/clear
        wb_write(A_CTRL, 32'h5);
        repeat (10) @(posedge clk);
        #1;
        chk("t2_zou_val", 32'(dac_val), 32'h0);
        wb_read(A_RIS, rd); chk("t2_ris", rd, 32'h3);
        chk("t2_irq_masked", 32'(irq), 32'd0);
        wb_write(A_IM, 32'h2);
        chk("t2_irq_on", 32'(irq), 32'd1);
        wb_write(A_CTRL, 32'h4);
        wb_write(A_IC, 32'h2);
        chk("t2_irq_off", 32'(irq), 32'd0);
        wb_read(A_RIS, rd); chk("t2_ris_after_ic", rd, 32'h1);
        wb_write(A_IM, 32'h0);
        wb_write(A_IC, 32'h7);

        // T3: overflow on the 17th push; only 16 samples ever play
        for (int i = 0; i < 17; i++) begin
            wb_write(A_DATA, 32'h100 + 32'(i));
            if (i < 16) sb.push_back(12'h100 + 12'(i));
        end
        wb_read(A_STATUS, rd); chk("t3_status_full", rd, 32'h1002);
        wb_read(A_RIS, rd);    chk("t3_ris_ovf", rd, 32'h4);
        wb_write(A_PRESC, 32'd0);
        wb_write(A_CTRL, 32'h1);
        wait_sb_empty(60);
        repeat (4) @(posedge clk);
        wb_write(A_CTRL, 32'h0);
        chk("t3_last_val", 32'(dac_val), 32'h10F);
        wb_write(A_IC, 32'h7);

        // T4: FIFO-low fires the cycle after the level reaches THRESH
        wb_write(A_THRESH, 32'd2);
        for (int i = 0; i < 4; i++) begin
            wb_write(A_DATA, 32'h3C1 + 32'(i));
            sb.push_back(12'h3C1 + 12'(i));
        end
        wb_write(A_IC, 32'h7);
        wb_write(A_IM, 32'h1);
        wb_write(A_CTRL, 32'h1);
        chk("t4_irq_e0", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("t4_irq_e1", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("t4_irq_e2", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("t4_irq_e3", 32'(irq), 32'd1);
        wait_sb_empty(20);
        wb_write(A_CTRL, 32'h0);
        wb_write(A_IM, 32'h0);
        wb_write(A_IC, 32'h7);

        // T5: flush discards queued samples
        for (int i = 0; i < 5; i++) wb_write(A_DATA, 32'h050 + 32'(i));
        wb_read(A_STATUS, rd); chk("t5_status_pre", rd, 32'h500);
        wb_write(A_CTRL, 32'h2);
        wb_read(A_STATUS, rd); chk("t5_status_post", rd, 32'h1);
        wb_read(A_CTRL, rd);   chk("t5_ctrl", rd, 32'h0);

        // T6: held strobe pushes once, ack lasts one cycle
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_DATA; dat_w = 32'h7AA;
        sb.push_back(12'h7AA);
        @(posedge clk); #1;
        chk("t6_ack_hi", 32'(ack), 32'd1);
        @(posedge clk); #1;
        chk("t6_ack_lo", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wb_read(A_STATUS, rd); chk("t6_single_push", rd, 32'h100);
        wb_read(32'h20, rd);   chk("t6_unmapped", rd, 32'hDEADBEEF);
        wb_read(A_DATA, rd);   chk("t6_data_rd", rd, 32'h0);

        // Async reset in the middle of a stream and a bus access
        wb_write(A_DATA, 32'h155); sb.push_back(12'h155);
        wb_write(A_IM, 32'h7);
        wb_write(A_PRESC, 32'd3);
        wb_write(A_CTRL, 32'h1);
        for (int n = 0; n < 40 && sb.size() > 1; n++) begin
            @(posedge clk); #1;
        end
        chk("t6_first_out", 32'(sb.size()), 32'd1);
        chk("t6_irq_pre", 32'(irq), 32'd1);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS;
        @(posedge clk); #1;
        chk("t6_ack_pre", 32'(ack), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_val", 32'(dac_val), 32'd0);
        chk("t6_rst_irq", 32'(irq), 32'd0);
        chk("t6_rst_ack", 32'(ack), 32'd0);
        chk("t6_rst_ena", 32'(dac_ena), 32'd0);
        sb.delete();
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst = 1'b0;
        wb_read(A_STATUS, rd); chk("t6_post_status", rd, 32'h1);
        wb_read(A_THRESH, rd); chk("t6_post_thresh", rd, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dac_wb_wrapper
`default_nettype wire
